// File: rtl/l1d_data_pipe_arb_n_if.sv
// Request/response bundle between the L1D data-RAM requesters and the data-pipe arbiter.
// The arbiter attaches via 'slave'; the requester/pipe side (or a bench) uses 'master'.
interface l1d_data_pipe_arb_n_if #(
    parameter int NUM_CH = 3,
    parameter int PLD_W  = 64,
    parameter int CH_W   = $clog2(NUM_CH)
);
    // Strict valid/ready: a source holds vld and its payload stable until rdy; a beat moves on vld & rdy.
    logic [NUM_CH-1:0]       req_vld;
    logic [NUM_CH-1:0]       req_rdy;
    logic [NUM_CH-1:0]       req_last;
    logic [NUM_CH*PLD_W-1:0] req_pld;
    logic                    out_vld;
    logic                    out_rdy;
    logic [PLD_W-1:0]        out_pld;
    logic [CH_W-1:0]         out_ch_id;
    logic                    out_last;

    modport master (
        output req_vld, req_last, req_pld, out_rdy,
        input  req_rdy, out_vld, out_pld, out_ch_id, out_last
    );

    modport slave (
        input  req_vld, req_last, req_pld, out_rdy,
        output req_rdy, out_vld, out_pld, out_ch_id, out_last
    );
endinterface

// File: rtl/l1d_data_pipe_arb_n.sv
// N-channel arbiter merging requester beats into the single L1D data-RAM pipe through a
// registered output slice; fixed-priority with starvation promotion, or round-robin; bursts lock the grant.
module l1d_data_pipe_arb_n #(
    parameter int NUM_CH    = 3,
    parameter int PLD_W     = 64,
    parameter int ARB_MODE  = 0,
    parameter int STARVE_TH = 8,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    l1d_data_pipe_arb_n_if.slave bus,
    output logic                dbg_lock_o,
    output logic [CH_W-1:0]     dbg_lock_ch_o,
    output logic [CH_W-1:0]     dbg_rr_ptr_o
);

    localparam logic [7:0] TH = 8'(STARVE_TH);

    logic                slot_free;
    logic                accept;
    logic [NUM_CH-1:0]   gnt;
    logic [NUM_CH-1:0]   starved;
    logic [CH_W-1:0]     gnt_idx;
    logic [PLD_W-1:0]    gnt_pld;
    logic                gnt_last;

    logic                out_vld_q,   out_vld_d;
    logic [PLD_W-1:0]    out_pld_q,   out_pld_d;
    logic [CH_W-1:0]     out_ch_id_q, out_ch_id_d;
    logic                out_last_q,  out_last_d;
    logic                lock_q,      lock_d;
    logic [CH_W-1:0]     lock_ch_q,   lock_ch_d;
    logic [CH_W-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [7:0]          starve_q [NUM_CH];
    logic [7:0]          starve_d [NUM_CH];

    assign slot_free = !out_vld_q || bus.out_rdy;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            starved[i] = (ARB_MODE == 0) && bus.req_vld[i] && (starve_q[i] == TH);
        end
    end

    // Grant is held at zero in reset and while the output slot is stalled.
    always_comb begin : grant
        logic found;
        gnt   = '0;
        found = 1'b0;
        if (!rst && slot_free) begin
            if (lock_q) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (lock_ch_q == CH_W'(i)) gnt[i] = bus.req_vld[i];
                end
            end else if (|starved) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (starved[i] && !found) begin
                        gnt[i] = 1'b1;
                        found  = 1'b1;
                    end
                end
            end else if (ARB_MODE == 0) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (bus.req_vld[i] && !found) begin
                        gnt[i] = 1'b1;
                        found  = 1'b1;
                    end
                end
            end else begin
                // Visit channels in order rr_ptr, rr_ptr+1, ... wrapping; first valid one wins.
                for (int k = 0; k < NUM_CH; k++) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (!found && bus.req_vld[i] && (((int'(rr_ptr_q) + k) % NUM_CH) == i)) begin
                            gnt[i] = 1'b1;
                            found  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_idx  = '0;
        gnt_pld  = '0;
        gnt_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                gnt_idx  = CH_W'(i);
                gnt_pld  = bus.req_pld[i*PLD_W +: PLD_W];
                gnt_last = bus.req_last[i];
            end
        end
    end

    assign accept      = |gnt;
    assign bus.req_rdy = gnt;

    always_comb begin
        out_vld_d   = out_vld_q;
        out_pld_d   = out_pld_q;
        out_ch_id_d = out_ch_id_q;
        out_last_d  = out_last_q;
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            out_vld_d   = 1'b1;
            out_pld_d   = gnt_pld;
            out_ch_id_d = gnt_idx;
            out_last_d  = gnt_last;
            if (!gnt_last) begin
                lock_d    = 1'b1;
                lock_ch_d = gnt_idx;
            end else begin
                lock_d = 1'b0;
                if (ARB_MODE != 0) begin
                    rr_ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
        end else if (slot_free) begin
            out_vld_d = 1'b0;
        end
    end

    // Waiting counters: a grant with last clears; a beat from another channel bumps up to TH.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            starve_d[i] = starve_q[i];
            if (ARB_MODE != 0) begin
                starve_d[i] = '0;
            end else if (accept && gnt[i]) begin
                if (bus.req_last[i]) starve_d[i] = '0;
            end else if (accept && bus.req_vld[i] && (starve_q[i] != TH)) begin
                starve_d[i] = starve_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q   <= 1'b0;
            out_pld_q   <= '0;
            out_ch_id_q <= '0;
            out_last_q  <= 1'b0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
            rr_ptr_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) starve_q[i] <= '0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_pld_q   <= out_pld_d;
            out_ch_id_q <= out_ch_id_d;
            out_last_q  <= out_last_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            for (int i = 0; i < NUM_CH; i++) starve_q[i] <= starve_d[i];
        end
    end

    assign bus.out_vld    = out_vld_q;
    assign bus.out_pld    = out_pld_q;
    assign bus.out_ch_id  = out_ch_id_q;
    assign bus.out_last   = out_last_q;
    assign dbg_lock_o     = lock_q;
    assign dbg_lock_ch_o  = lock_ch_q;
    assign dbg_rr_ptr_o   = rr_ptr_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_no_rdy_on_stall: assert property (@(posedge clk) disable iff (rst)
        (out_vld_q && !bus.out_rdy) |-> (bus.req_rdy == '0));
    a_lock_ch_stable: assert property (@(posedge clk) disable iff (rst) lock_q |=> $stable(lock_ch_q));

endmodule

// File: tb/tb_l1d_data_pipe_arb_n.sv
// Directed bench: a fixed-priority instance and a round-robin instance share clock and reset;
// each step drives requests, checks req_rdy before the edge and the registered slice after it.
module tb_l1d_data_pipe_arb_n;

    localparam int NUM_CH = 3;
    localparam int PLD_W  = 64;
    localparam int CH_W   = 2;

    localparam logic [63:0] P0 = 64'hF0F0_0000_0000_0000;
    localparam logic [63:0] P1 = 64'hF1F1_0000_0000_0001;
    localparam logic [63:0] P2 = 64'hF2F2_0000_0000_0002;
    localparam logic [63:0] R0 = 64'hAAAA_0000_0000_0010;
    localparam logic [63:0] R1 = 64'hAAAA_0000_0000_0011;
    localparam logic [63:0] R2 = 64'hAAAA_0000_0000_0012;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic            f_lock, r_lock;
    logic [CH_W-1:0] f_lock_ch, r_lock_ch, f_rr, r_rr;

    l1d_data_pipe_arb_n_if #(.NUM_CH(NUM_CH), .PLD_W(PLD_W)) f_if ();
    l1d_data_pipe_arb_n_if #(.NUM_CH(NUM_CH), .PLD_W(PLD_W)) r_if ();

    l1d_data_pipe_arb_n #(.NUM_CH(NUM_CH), .PLD_W(PLD_W), .ARB_MODE(0), .STARVE_TH(8)) u_fix (
        .clk(clk), .rst(rst), .bus(f_if),
        .dbg_lock_o(f_lock), .dbg_lock_ch_o(f_lock_ch), .dbg_rr_ptr_o(f_rr)
    );

    l1d_data_pipe_arb_n #(.NUM_CH(NUM_CH), .PLD_W(PLD_W), .ARB_MODE(1), .STARVE_TH(8)) u_rr (
        .clk(clk), .rst(rst), .bus(r_if),
        .dbg_lock_o(r_lock), .dbg_lock_ch_o(r_lock_ch), .dbg_rr_ptr_o(r_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_f(input logic [2:0] vld, input logic [2:0] last,
                           input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2);
        f_if.req_vld  = vld;
        f_if.req_last = last;
        f_if.req_pld  = {p2, p1, p0};
    endtask

    task automatic drive_r(input logic [2:0] vld, input logic [2:0] last,
                           input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2);
        r_if.req_vld  = vld;
        r_if.req_last = last;
        r_if.req_pld  = {p2, p1, p0};
    endtask

    function automatic logic [63:0] fpld(input int ch);
        return (ch == 0) ? P0 : (ch == 1) ? P1 : P2;
    endfunction

    function automatic logic [63:0] rpld(input int ch);
        return (ch == 0) ? R0 : (ch == 1) ? R1 : R2;
    endfunction

    initial begin
        int exp1 [11];
        int exp2 [7];
        int exp2_rr [7];
        exp1    = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0};
        exp2    = '{0, 1, 2, 0, 1, 2, 0};
        exp2_rr = '{1, 2, 0, 1, 2, 0, 1};

        // Reset state
        rst = 1'b1;
        drive_f(3'b000, 3'b000, '0, '0, '0);
        drive_r(3'b000, 3'b000, '0, '0, '0);
        f_if.out_rdy = 1'b1;
        r_if.out_rdy = 1'b1;
        tick();
        tick();
        chk("rst_out_vld", 64'(f_if.out_vld), 64'd0);
        chk("rst_out_pld", f_if.out_pld, 64'd0);
        chk("rst_out_ch_id", 64'(f_if.out_ch_id), 64'd0);
        chk("rst_out_last", 64'(f_if.out_last), 64'd0);
        chk("rst_lock", 64'(f_lock), 64'd0);
        chk("rst_rr_ptr", 64'(r_rr), 64'd0);
        chk("rst_rr_out_vld", 64'(r_if.out_vld), 64'd0);
        drive_f(3'b111, 3'b111, P0, P1, P2);
        #1;
        chk("rst_req_rdy", 64'(f_if.req_rdy), 64'd0);
        tick();
        chk("rst_no_accept", 64'(f_if.out_vld), 64'd0);
        rst = 1'b0;

        // Fixed priority with starvation promotion
        for (int c = 0; c < 11; c++) begin
            #1;
            chk($sformatf("t1_rdy_%0d", c), 64'(f_if.req_rdy), 64'(3'b001 << exp1[c]));
            tick();
            chk($sformatf("t1_vld_%0d", c), 64'(f_if.out_vld), 64'd1);
            chk($sformatf("t1_ch_%0d", c), 64'(f_if.out_ch_id), 64'(exp1[c]));
            chk($sformatf("t1_pld_%0d", c), f_if.out_pld, fpld(exp1[c]));
        end
        drive_f(3'b000, 3'b000, P0, P1, P2);
        tick();
        chk("t1_idle_vld", 64'(f_if.out_vld), 64'd0);

        // Burst lock: ch2 four beats, ch0 waits; one idle cycle of ch2 mid-burst
        drive_f(3'b100, 3'b000, P0, P1, 64'hB1);
        #1;
        chk("t3_rdy_b1", 64'(f_if.req_rdy), 64'b100);
        tick();
        chk("t3_ch_b1", 64'(f_if.out_ch_id), 64'd2);
        chk("t3_last_b1", 64'(f_if.out_last), 64'd0);
        chk("t3_pld_b1", f_if.out_pld, 64'hB1);
        chk("t3_lock_b1", 64'(f_lock), 64'd1);
        chk("t3_lock_ch_b1", 64'(f_lock_ch), 64'd2);
        drive_f(3'b101, 3'b001, 64'hA0, P1, 64'hB2);
        #1;
        chk("t3_rdy_b2", 64'(f_if.req_rdy), 64'b100);
        tick();
        chk("t3_pld_b2", f_if.out_pld, 64'hB2);
        drive_f(3'b001, 3'b001, 64'hA0, P1, 64'hB2);
        #1;
        chk("t3_rdy_gap", 64'(f_if.req_rdy), 64'b000);
        tick();
        chk("t3_vld_gap", 64'(f_if.out_vld), 64'd0);
        chk("t3_lock_gap", 64'(f_lock), 64'd1);
        drive_f(3'b101, 3'b001, 64'hA0, P1, 64'hB3);
        #1;
        chk("t3_rdy_b3", 64'(f_if.req_rdy), 64'b100);
        tick();
        chk("t3_pld_b3", f_if.out_pld, 64'hB3);
        drive_f(3'b101, 3'b101, 64'hA0, P1, 64'hB4);
        #1;
        chk("t3_rdy_b4", 64'(f_if.req_rdy), 64'b100);
        tick();
        chk("t3_pld_b4", f_if.out_pld, 64'hB4);
        chk("t3_last_b4", 64'(f_if.out_last), 64'd1);
        chk("t3_unlock", 64'(f_lock), 64'd0);
        drive_f(3'b001, 3'b001, 64'hA0, P1, 64'hB4);
        #1;
        chk("t3_rdy_ch0", 64'(f_if.req_rdy), 64'b001);
        tick();
        chk("t3_ch_ch0", 64'(f_if.out_ch_id), 64'd0);
        chk("t3_pld_ch0", f_if.out_pld, 64'hA0);

        // Backpressure: A0 held three cycles, then A1 and C1 follow without loss
        f_if.out_rdy = 1'b0;
        drive_f(3'b011, 3'b011, 64'hA1, 64'hC1, 64'hB4);
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("t4_rdy_stall_%0d", s), 64'(f_if.req_rdy), 64'd0);
            tick();
            chk($sformatf("t4_vld_stall_%0d", s), 64'(f_if.out_vld), 64'd1);
            chk($sformatf("t4_pld_stall_%0d", s), f_if.out_pld, 64'hA0);
            chk($sformatf("t4_ch_stall_%0d", s), 64'(f_if.out_ch_id), 64'd0);
        end
        f_if.out_rdy = 1'b1;
        #1;
        chk("t4_rdy_release", 64'(f_if.req_rdy), 64'b001);
        tick();
        chk("t4_pld_a1", f_if.out_pld, 64'hA1);
        chk("t4_ch_a1", 64'(f_if.out_ch_id), 64'd0);
        drive_f(3'b010, 3'b010, 64'hA1, 64'hC1, 64'hB4);
        #1;
        chk("t4_rdy_c1", 64'(f_if.req_rdy), 64'b010);
        tick();
        chk("t4_pld_c1", f_if.out_pld, 64'hC1);
        chk("t4_ch_c1", 64'(f_if.out_ch_id), 64'd1);
        drive_f(3'b000, 3'b000, '0, '0, '0);
        tick();
        chk("t4_idle_vld", 64'(f_if.out_vld), 64'd0);

        // Round robin, single-beat
        drive_r(3'b111, 3'b111, R0, R1, R2);
        for (int c = 0; c < 7; c++) begin
            #1;
            chk($sformatf("t2_rdy_%0d", c), 64'(r_if.req_rdy), 64'(3'b001 << exp2[c]));
            tick();
            chk($sformatf("t2_vld_%0d", c), 64'(r_if.out_vld), 64'd1);
            chk($sformatf("t2_ch_%0d", c), 64'(r_if.out_ch_id), 64'(exp2[c]));
            chk($sformatf("t2_pld_%0d", c), r_if.out_pld, rpld(exp2[c]));
            chk($sformatf("t2_rr_%0d", c), 64'(r_rr), 64'(exp2_rr[c]));
        end

        // Idle gap keeps rr_ptr
        drive_r(3'b000, 3'b000, R0, R1, R2);
        tick();
        chk("t6_vld_0", 64'(r_if.out_vld), 64'd0);
        chk("t6_rr_0", 64'(r_rr), 64'd1);
        tick();
        chk("t6_vld_1", 64'(r_if.out_vld), 64'd0);
        chk("t6_rr_1", 64'(r_rr), 64'd1);
        drive_r(3'b101, 3'b101, R0, R1, R2);
        #1;
        chk("t6_rdy_wrap", 64'(r_if.req_rdy), 64'b100);
        tick();
        chk("t6_ch_wrap", 64'(r_if.out_ch_id), 64'd2);
        chk("t6_rr_wrap", 64'(r_rr), 64'd0);
        drive_r(3'b001, 3'b001, R0, R1, R2);
        #1;
        chk("t6_rdy_ch0", 64'(r_if.req_rdy), 64'b001);
        tick();
        chk("t6_ch_ch0", 64'(r_if.out_ch_id), 64'd0);
        chk("t6_rr_ch0", 64'(r_rr), 64'd1);

        // Reset in the middle of a ch1 burst
        drive_r(3'b011, 3'b001, R0, 64'hD1, R2);
        #1;
        chk("t5_rdy_b1", 64'(r_if.req_rdy), 64'b010);
        tick();
        chk("t5_ch_b1", 64'(r_if.out_ch_id), 64'd1);
        chk("t5_last_b1", 64'(r_if.out_last), 64'd0);
        chk("t5_lock_b1", 64'(r_lock), 64'd1);
        chk("t5_lock_ch_b1", 64'(r_lock_ch), 64'd1);
        drive_r(3'b011, 3'b001, R0, 64'hD2, R2);
        #1;
        chk("t5_rdy_b2", 64'(r_if.req_rdy), 64'b010);
        tick();
        chk("t5_pld_b2", r_if.out_pld, 64'hD2);
        rst = 1'b1;
        drive_r(3'b011, 3'b001, R0, 64'hD3, R2);
        #1;
        chk("t5_rdy_in_rst", 64'(r_if.req_rdy), 64'd0);
        tick();
        chk("t5_vld_after_rst", 64'(r_if.out_vld), 64'd0);
        chk("t5_pld_after_rst", r_if.out_pld, 64'd0);
        chk("t5_lock_after_rst", 64'(r_lock), 64'd0);
        chk("t5_lock_ch_after_rst", 64'(r_lock_ch), 64'd0);
        chk("t5_rr_after_rst", 64'(r_rr), 64'd0);
        rst = 1'b0;
        drive_r(3'b011, 3'b011, R0, 64'hD1, R2);
        #1;
        chk("t5_rdy_restart", 64'(r_if.req_rdy), 64'b001);
        tick();
        chk("t5_ch_restart", 64'(r_if.out_ch_id), 64'd0);
        chk("t5_pld_restart", r_if.out_pld, R0);
        chk("t5_rr_restart", 64'(r_rr), 64'd1);

        drive_r(3'b000, 3'b000, '0, '0, '0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l1d_data_pipe_arb_n.md
Name: l1d_data_pipe_arb_n

Overview:
- Parametrised N-channel arbiter that merges data-RAM access requests into the single L1D data RAM pipe. Typical requesters: store write, evict read, linefill write.
- Next generation of the fixed 3-way data-pipe arbiter. Adds:
  - selectable fixed-priority or round-robin mode;
  - multi-beat burst locking;
  - starvation promotion;
  - a registered output slice.
- Sits between the request producers and the data RAM pipeline stage.

Parameters:
- NUM_CH, 3: number of requesting channels (2..8); channel 0 has the highest fixed priority.
- PLD_W, 64: payload width per channel (packed data RAM pipe payload).
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- STARVE_TH, 8: wait-cycle threshold for starvation promotion (1..255); fixed mode only.
- CH_W, $clog2(NUM_CH): channel id width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_vld  in  NUM_CH  per-channel request valid
- req_rdy  out  NUM_CH  per-channel accept
- req_last  in  NUM_CH  beat is last of burst (1 for single-beat ops)
- req_pld  in  NUM_CH*PLD_W  per-channel payload, channel i at [i*PLD_W +: PLD_W]
- out_vld  out  1  registered pipe valid
- out_rdy  in  1  pipe ready
- out_pld  out  PLD_W  registered payload
- out_ch_id  out  CH_W  source channel of out_pld
- out_last  out  1  registered last flag

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high on rst.
- Reset values:
  - out_vld=0, out_pld=0, out_ch_id=0, out_last=0;
  - rr_ptr=0, lock=0, lock_ch=0, all starve counters=0.
  - req_rdy evaluates to all-ones-eligible only after reset deasserts. During rst=1, req_rdy=0.
- Handshakes:
  - Producer holds req_vld/req_pld/req_last stable until req_rdy.
  - Transfer occurs when vld&rdy.
- Output slot:
  - slot_free = !out_vld | out_rdy.
  - Latency is 1 cycle from input accept to out_vld. Full throughput of 1 beat/cycle.
- Grant (combinational, one-hot):
  - Grant is evaluated only when slot_free. req_rdy[i] = slot_free & gnt[i].
  - Exactly one channel is granted per cycle, or none if there are no requests.
- Grant priority order:
  1. Lock: if lock=1, only lock_ch is eligible. Other channels get rdy=0 even if lock_ch is idle.
  2. Starvation (ARB_MODE=0): lowest-index channel whose counter == STARVE_TH.
  3. ARB_MODE=0: lowest-index valid channel.
  4. ARB_MODE=1: first valid channel searching upward from rr_ptr, wrapping at NUM_CH-1 to 0.
- On accept of beat from channel g:
  - out_pld <= req_pld[g]; out_ch_id <= g; out_last <= req_last[g]; out_vld <= 1.
  - If req_last[g]=0: lock <= 1, lock_ch <= g.
  - If req_last[g]=1: lock <= 0. In RR mode, rr_ptr <= (g+1) mod NUM_CH.
- Output hold: if out_vld & !out_rdy, out_* hold their values and no input is accepted.
- No accept: if slot_free and no grant, out_vld <= 0.
- rr_ptr update: advances only on a last beat, never mid-burst.
- Starve counter[i] (ARB_MODE=0; held at 0 in mode 1):
  - +1 on any cycle where req_vld[i]=1 and a beat is accepted from another channel.
  - Saturates at STARVE_TH.
  - Cleared when channel i has its last beat accepted.
- Simultaneous events: a channel granted in the same cycle it reaches threshold is cleared, not incremented.
- Reset mid-burst: lock, counters and the output slot all clear. In-flight out beat is dropped; upstream must also be reset.
- Assertions:
  - gnt is onehot0;
  - no req_rdy while out_vld & !out_rdy;
  - lock_ch unchanged while lock=1.

Test Plan:
1. Mode 0, req_vld=3'b111 all last=1, out_rdy=1 -> ch0 accepted every cycle; ch1/ch2 counters reach 8 after 8 cycles; cycle 9 grants ch1, cycle 10 grants ch2 (ch2 counter saturated), then ch0.
2. Mode 1, all 3 valid, single-beat, out_rdy=1 -> out_ch_id sequence 0,1,2,0,1,2; out_vld=1 every cycle from cycle 1.
3. Burst lock: ch2 issues 4 beats (last on beat 4) while ch0 valid -> out_ch_id=2 for 4 consecutive beats; ch0 req_rdy=0 until after beat 4; ch0 granted next.
4. Backpressure: out_rdy=0 for 3 cycles with out_vld=1 -> out_pld/out_ch_id stable, all req_rdy=0; out_rdy=1 -> next beat appears 1 cycle later, no loss or duplication.
5. Reset mid-burst: rst=1 for 1 cycle after beat 2 of a ch1 4-beat burst -> next cycle out_vld=0, lock=0, counters 0; rr_ptr=0 so ch0 wins in RR mode.
6. Idle gap: no req_vld with slot free -> out_vld drops to 0 the following cycle; rr_ptr unchanged.
